uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- Memory-mapped serial transmitter; a responder on the CPU's peripheral bus, alongside the two timer counters.
- The bridge decodes its address window and drives Addr/WE/Din, and it muxes Dout back into pr_rd.
- Serialises CPU-written bytes as 8N1 frames on a single output pin.
- Raises a level interrupt that the bridge routes into one hwint bit.

Parameters:
- FIFO_DEPTH, 4, number of byte entries in the transmit FIFO; must be a power of 2, at least 2.
- DIV_RESET, 32'd15, reset value of DIVISOR; bit period is DIVISOR+1 clk cycles.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- Addr  input  30  word address (pr_a[31:2]); only Addr[3:2] is decoded
- WE  input  1  write strobe; the bridge has already qualified it with address-window select
- Din  input  32  write data
- Dout  output  32  combinational read data for the register selected by Addr[3:2]
- IRQ  output  1  level interrupt request
- tx  output  1  serial line, registered, idles high

Behaviour:
- Register map (Addr[3:2]):
  - 0 DATA: write pushes Din[7:0]; read returns 0.
  - 1 STATUS, read: bit0 busy (FSM not IDLE), bit1 full, bit2 empty, bit3 overflow (sticky), bits[7:4] FIFO count, rest 0. Write of any value clears overflow.
  - 2 CTRL: bit0 enable, bit1 irq_en, rest read 0.
  - 3 DIVISOR: full 32 bits, R/W.
- Reset (asynchronous, reset==0):
  - tx=1, FSM=IDLE, FIFO empty, overflow=0, CTRL=0, DIVISOR=DIV_RESET.
  - IRQ=0. This follows from irq_en=0.
  - Dout follows from the reset register values.
- DATA write with FIFO full: byte is dropped, overflow is set, FIFO is unchanged.
- Push and pop in the same cycle are both honoured; count is unchanged.
  - When full, a pop in the same cycle does NOT make room for the push; the push is treated as overflow.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START at an edge where enable=1 and FIFO non-empty. Action: pop the FIFO head into an 8-bit shift register, latch DIVISOR into the bit counter reload, tx<=0.
  - Each state holds for DIVISOR_latched+1 cycles, counted by a 32-bit down-counter.
  - START -> DATA: tx<=shift[0]. Shift right on every bit boundary, 8 bits LSB first, tracked by a 3-bit index.
  - DATA -> STOP after bit 7: tx<=1.
  - STOP -> IDLE after its period.
  - If enable=1 and the FIFO is non-empty at the end of STOP, go directly to START (back-to-back frames, no idle gap).
- Frame length is exactly 10*(DIVISOR_latched+1) cycles.
- Latency, write into an empty idle enabled block:
  - the write edge E0 makes the FIFO non-empty;
  - edge E1 pops the byte and drives tx low.
- A DIVISOR write mid-frame takes effect only at the next frame start.
- Clearing enable mid-frame: the current frame completes; no new frame starts. FIFO contents are retained.
- IRQ = irq_en & empty & ~busy, combinational from registers. It is glitch-free because all terms are registered.
- A reset asserted mid-frame aborts immediately: tx=1, FIFO flushed.
- Simultaneous DATA write and STATUS read are independent; the read reflects pre-edge state.

Decomposition:
- const.v (shared macros) holds:
  - register offsets UART_DATA/STATUS/CTRL/DIV (2'd0..3);
  - FSM state encodings;
  - STATUS bit positions;
  - the bridge base address of the window.
- One natural sub-module, uart_tx_fifo: synchronous FIFO parameterised by depth and width 8.
  - Ports: clk, reset, push, pop, din, dout, full, empty, count.
  - Reject-on-full is implemented inside it.
- The FSM, register file and read mux stay in uart_tx.

Test Plan:
- Reset: drive reset=0 mid-run, then release -> tx=1, IRQ=0, STATUS read = 0x00000004, DIVISOR read = 15, CTRL read = 0.
- Single byte: DIVISOR=3, CTRL=1, write DATA=0xA5 -> tx low from the edge after the write for 4 cycles.
  - Then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high for 4 cycles.
  - Busy for exactly 40 cycles.
- Overflow: CTRL=0, write 5 bytes with FIFO_DEPTH=4 -> STATUS count=4, full=1, overflow=1.
  - A write to STATUS clears overflow only; count stays 4.
- Back-to-back and IRQ:
  - DIVISOR=0, CTRL=3, write 0x01 and 0x80 -> two contiguous 10-cycle frames with no idle cycle between them.
  - IRQ rises the cycle after the second stop bit ends and stays 1 until the next DATA write.
- Disable mid-frame: CTRL=1, DIVISOR=1, two bytes queued; write CTRL=0 during frame 1 DATA.
  - Frame 1 completes; tx stays 1; STATUS count=1, busy=0.
- Reset mid-frame: assert reset during the DATA state -> tx=1 asynchronously, and STATUS=0x4 after release.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared definitions for the uart_tx peripheral: register offsets, STATUS
// bit positions, bridge window base and transmitter FSM states.
package uart_tx_pkg;

  localparam logic [1:0] UART_DATA   = 2'd0;
  localparam logic [1:0] UART_STATUS = 2'd1;
  localparam logic [1:0] UART_CTRL   = 2'd2;
  localparam logic [1:0] UART_DIV    = 2'd3;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_EMPTY   = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_CNT_LSB = 4;

  localparam logic [31:0] UART_BASE_ADDR = 32'h0000_7F30;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_tx_if.sv
// Peripheral-bus port of the transmitter as seen from the CPU bridge.
interface uart_tx_if;

  logic [29:0] Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;

  modport master (output Addr, output WE, output Din, input Dout);
  modport slave  (input Addr, input WE, input Din, output Dout);

endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO with first-word-fall-through head; pushes while full
// are dropped here, so a same-cycle pop never makes room for them.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_tx.sv
// Memory-mapped 8N1 serial transmitter: register file, read mux, transmit
// FIFO and the frame FSM driving the registered tx pin.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] DIV_RESET  = 32'd15
) (
  input  logic       clk,
  input  logic       reset,
  uart_tx_if.slave   bus,
  output logic       IRQ,
  output logic       tx
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  tx_state_e   state, state_next;
  logic [1:0]  sel;
  logic        push, pop, frame_start, bit_end, busy;
  logic        fifo_full, fifo_empty;
  logic [7:0]  fifo_dout;
  logic [CW-1:0] fifo_count;
  logic        enable, irq_en, overflow;
  logic [31:0] divisor, reload, cnt, status;
  logic [7:0]  shift;
  logic [2:0]  bit_idx;
  logic        unused_addr_bits;

  assign sel              = bus.Addr[3:2];
  assign unused_addr_bits = ^{bus.Addr[29:4], bus.Addr[1:0]};
  assign push             = bus.WE && (sel == UART_DATA);
  assign busy             = (state != IDLE);
  assign bit_end          = (cnt == '0);
  assign IRQ              = irq_en & fifo_empty & ~busy;

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (bus.Din[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      enable   <= 1'b0;
      irq_en   <= 1'b0;
      divisor  <= DIV_RESET;
      overflow <= 1'b0;
    end else begin
      if (bus.WE) begin
        case (sel)
          UART_STATUS: overflow <= 1'b0;
          UART_CTRL: begin
            enable <= bus.Din[0];
            irq_en <= bus.Din[1];
          end
          UART_DIV: divisor <= bus.Din;
          default: ;
        endcase
      end
      if (push && fifo_full) overflow <= 1'b1;
    end
  end

  always_comb begin
    status                      = '0;
    status[STAT_BUSY]           = busy;
    status[STAT_FULL]           = fifo_full;
    status[STAT_EMPTY]          = fifo_empty;
    status[STAT_OVF]            = overflow;
    status[STAT_CNT_LSB +: 4]   = 4'(fifo_count);
    bus.Dout                    = '0;
    case (sel)
      UART_STATUS: bus.Dout = status;
      UART_CTRL:   bus.Dout = {30'd0, irq_en, enable};
      UART_DIV:    bus.Dout = divisor;
      default:     bus.Dout = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // A frame can start from IDLE or straight out of STOP, giving gapless back-to-back frames.
  always_comb begin
    state_next  = state;
    pop         = 1'b0;
    frame_start = 1'b0;
    case (state)
      IDLE: begin
        if (enable && !fifo_empty) begin
          state_next  = START;
          pop         = 1'b1;
          frame_start = 1'b1;
        end
      end
      START: if (bit_end) state_next = DATA;
      DATA:  if (bit_end && (bit_idx == 3'd7)) state_next = STOP;
      STOP: begin
        if (bit_end) begin
          if (enable && !fifo_empty) begin
            state_next  = START;
            pop         = 1'b1;
            frame_start = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The divisor is sampled only at frame start so mid-frame writes cannot stretch a frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx      <= 1'b1;
      cnt     <= '0;
      reload  <= '0;
      shift   <= '0;
      bit_idx <= '0;
    end else if (frame_start) begin
      tx      <= 1'b0;
      shift   <= fifo_dout;
      reload  <= divisor;
      cnt     <= divisor;
      bit_idx <= '0;
    end else if (busy) begin
      if (bit_end) begin
        cnt <= reload;
        case (state)
          START: begin
            tx    <= shift[0];
            shift <= shift >> 1;
          end
          DATA: begin
            tx      <= (bit_idx == 3'd7) ? 1'b1 : shift[0];
            shift   <= shift >> 1;
            bit_idx <= bit_idx + 3'd1;
          end
          default: tx <= 1'b1;
        endcase
      end else begin
        cnt <= cnt - 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx: register access, frame timing,
// overflow, back-to-back frames, IRQ, disable and reset behaviour.
module tb_uart_tx;
  import uart_tx_pkg::*;

  logic clk;
  logic reset;
  logic irq;
  logic tx;
  int   total;
  int   bad;

  uart_tx_if bus ();

  uart_tx #(.FIFO_DEPTH(4), .DIV_RESET(32'd15)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .IRQ   (irq),
    .tx    (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Drives one bus write; returns 1 ns after the capturing edge.
  task automatic apply_stimulus(input logic [1:0] off, input logic [31:0] data);
    bus.Addr = {26'd0, off, 2'b00};
    bus.Din  = data;
    bus.WE   = 1'b1;
    @(posedge clk);
    #1;
    bus.WE   = 1'b0;
    bus.Din  = '0;
  endtask

  task automatic read_reg(input logic [1:0] off, output logic [31:0] data);
    bus.Addr = {26'd0, off, 2'b00};
    #1;
    data = bus.Dout;
  endtask

  initial begin
    logic [31:0] rd;
    logic [9:0]  frame;
    logic [19:0] seq;

    total    = 0;
    bad      = 0;
    reset    = 1'b0;
    bus.Addr = '0;
    bus.WE   = 1'b0;
    bus.Din  = '0;

    // Reset values
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk); #1;
    check_output("rst_tx", {31'd0, tx}, 32'd1);
    check_output("rst_irq", {31'd0, irq}, 32'd0);
    read_reg(UART_STATUS, rd); check_output("rst_status", rd, 32'h4);
    read_reg(UART_DIV, rd);    check_output("rst_div", rd, 32'd15);
    read_reg(UART_CTRL, rd);   check_output("rst_ctrl", rd, 32'd0);
    read_reg(UART_DATA, rd);   check_output("rst_data_rd", rd, 32'd0);

    // Single byte 0xA5 at 4 cycles per bit
    apply_stimulus(UART_DIV, 32'd3);
    apply_stimulus(UART_CTRL, 32'd1);
    read_reg(UART_DIV, rd);  check_output("div_rw", rd, 32'd3);
    apply_stimulus(UART_DATA, 32'h0000_00A5);
    check_output("e0_tx_idle", {31'd0, tx}, 32'd1);
    read_reg(UART_STATUS, rd); check_output("e0_status", rd, 32'h10);
    frame = {1'b1, 8'hA5, 1'b0};
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      check_output("a5_tx", {31'd0, tx}, {31'd0, frame[k/4]});
      read_reg(UART_STATUS, rd);
      check_output("a5_busy", {31'd0, rd[0]}, 32'd1);
    end
    @(posedge clk); #1;
    check_output("a5_end_tx", {31'd0, tx}, 32'd1);
    read_reg(UART_STATUS, rd); check_output("a5_end_status", rd, 32'h4);

    // Overflow with the transmitter disabled
    apply_stimulus(UART_CTRL, 32'd0);
    for (int i = 1; i <= 5; i++) apply_stimulus(UART_DATA, 32'(i));
    read_reg(UART_STATUS, rd); check_output("ovf_status", rd, 32'h4A);
    apply_stimulus(UART_STATUS, 32'hFFFF_FFFF);
    read_reg(UART_STATUS, rd); check_output("ovf_clear", rd, 32'h42);
    apply_stimulus(UART_DIV, 32'd0);
    apply_stimulus(UART_CTRL, 32'd1);
    repeat (45) @(posedge clk);
    #1;
    read_reg(UART_STATUS, rd); check_output("flush_status", rd, 32'h4);

    // Back-to-back frames and IRQ
    apply_stimulus(UART_CTRL, 32'd3);
    check_output("irq_idle_empty", {31'd0, irq}, 32'd1);
    apply_stimulus(UART_DATA, 32'h01);
    check_output("irq_after_push", {31'd0, irq}, 32'd0);
    apply_stimulus(UART_DATA, 32'h80);
    seq = {1'b1, 8'h80, 1'b0, 1'b1, 8'h01, 1'b0};
    for (int k = 0; k < 20; k++) begin
      check_output("b2b_tx", {31'd0, tx}, {31'd0, seq[k]});
      check_output("b2b_irq", {31'd0, irq}, 32'd0);
      @(posedge clk); #1;
    end
    check_output("b2b_irq_rise", {31'd0, irq}, 32'd1);
    check_output("b2b_tx_idle", {31'd0, tx}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check_output("irq_hold", {31'd0, irq}, 32'd1);
    apply_stimulus(UART_CTRL, 32'd2);
    check_output("irq_hold_ctrl", {31'd0, irq}, 32'd1);
    apply_stimulus(UART_DATA, 32'h55);
    check_output("irq_drop_data", {31'd0, irq}, 32'd0);

    // Disable during frame 1 data bits
    apply_stimulus(UART_DIV, 32'd1);
    apply_stimulus(UART_DATA, 32'h3C);
    apply_stimulus(UART_CTRL, 32'd1);
    frame = {1'b1, 8'h55, 1'b0};
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      check_output("dis_tx", {31'd0, tx}, {31'd0, frame[k/2]});
      if (k == 3) begin
        bus.Addr = {26'd0, UART_CTRL, 2'b00};
        bus.Din  = 32'd0;
        bus.WE   = 1'b1;
      end else if (k == 4) begin
        bus.WE   = 1'b0;
      end
    end
    @(posedge clk); #1;
    read_reg(UART_STATUS, rd); check_output("dis_status", rd, 32'h10);
    check_output("dis_tx_end", {31'd0, tx}, 32'd1);
    repeat (5) @(posedge clk);
    #1;
    check_output("dis_tx_hold", {31'd0, tx}, 32'd1);
    read_reg(UART_STATUS, rd); check_output("dis_status_hold", rd, 32'h10);

    // Reset asserted during the data bits of 0x3C
    apply_stimulus(UART_CTRL, 32'd1);
    repeat (4) @(posedge clk);
    #1;
    check_output("pre_rst_tx", {31'd0, tx}, 32'd0);
    #2 reset = 1'b0;
    #1;
    check_output("async_rst_tx", {31'd0, tx}, 32'd1);
    check_output("async_rst_irq", {31'd0, irq}, 32'd0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk); #1;
    read_reg(UART_STATUS, rd); check_output("post_rst_status", rd, 32'h4);
    read_reg(UART_CTRL, rd);   check_output("post_rst_ctrl", rd, 32'd0);
    read_reg(UART_DIV, rd);    check_output("post_rst_div", rd, 32'd15);
    check_output("post_rst_tx", {31'd0, tx}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
